// File: rtl/bank_mapper.sv
// bank_mapper: 6509-style execution/indirect bank mapper for a 65xx CPU with SYNC.
// Optional register readback is built when BANK_READBACK_EN is defined.
module bank_mapper #(
    parameter int                    BANK_WIDTH = 4,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] EXEC_ADDR  = 16'h0000,
    parameter logic [ADDR_WIDTH-1:0] IND_ADDR   = 16'h0001,
    parameter logic [BANK_WIDTH-1:0] RESET_BANK = '1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  r_w,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [7:0]            data_in,
    output logic [7:0]            data_out,
    output logic                  data_oe,
    input  logic                  rdy,
    input  logic                  sync,
    output logic [BANK_WIDTH-1:0] address_bank,
    output logic                  ind_active
);
    typedef enum logic [2:0] {IDLE, OPERAND, PTR_LO, PTR_HI, DATA} state_t;

    state_t                state, state_nx;
    logic [BANK_WIDTH-1:0] exec_bank, ind_bank;
    logic                  advance, hit_exec, hit_ind, ind_opcode;

    assign advance    = rdy | !r_w;
    assign hit_exec   = address == EXEC_ADDR;
    assign hit_ind    = address == IND_ADDR;
    assign ind_opcode = (data_in == 8'hB1) || (data_in == 8'h91);

    // Bank registers load on any CPU write to their address; rdy is irrelevant to writes.
    always_ff @(posedge clock) begin
        if (reset) begin
            exec_bank <= RESET_BANK;
            ind_bank  <= RESET_BANK;
        end else if (!r_w) begin
            if (hit_exec) exec_bank <= data_in[BANK_WIDTH-1:0];
            if (hit_ind)  ind_bank  <= data_in[BANK_WIDTH-1:0];
        end
    end

    // Sequence state register; frozen on stalled read cycles.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else if (advance) state <= state_nx;
    end

    // Opcode fetch restarts the sequence; otherwise walk operand/pointer cycles and park in DATA.
    always_comb begin
        state_nx = state;
        if (sync) state_nx = ind_opcode ? OPERAND : IDLE;
        else begin
            case (state)
                OPERAND: state_nx = PTR_LO;
                PTR_LO:  state_nx = PTR_HI;
                PTR_HI:  state_nx = DATA;
                DATA:    state_nx = DATA;
                default: state_nx = IDLE;
            endcase
        end
    end

    assign ind_active   = (state == DATA) && !sync;
    assign address_bank = ind_active ? ind_bank : exec_bank;

`ifdef BANK_READBACK_EN
    // Readback drives the selected register with unused upper bits forced high.
    always_comb begin
        data_out = 8'hFF;
        data_out[BANK_WIDTH-1:0] = hit_exec ? exec_bank : ind_bank;
        data_oe = !reset && r_w && (hit_exec || hit_ind);
        if (!data_oe) data_out = 8'h00;
    end
`else
    assign data_out = 8'h00;
    assign data_oe  = 1'b0;
`endif
endmodule
